vmem_arbiter: RTL
=================

VMEM_ARBITER -- requirements
Module: vmem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port rd_en, input, 1 bit: the VGA scan side requests a pixel this cycle (tied to the vga_ctrl valid output).
REQ-004 SHALL have ports h_addr (input, 10 bits) and v_addr (input, 9 bits): the pixel coordinates for the read.
REQ-005 SHALL have ports rd_valid (output, 1 bit) and rd_data (output, 24 bits): the returned pixel, in RGB 8:8:8 order.
REQ-006 SHALL have ports wr_valid (input, 1), wr_addr (input, 19) and wr_data (input, 24): the write request from a drawing or keyboard client.
REQ-007 SHALL have port wr_ready, output, 1 bit: the write FIFO can accept an entry.
REQ-008 SHALL have memory-port outputs mem_en (1), mem_we (1), mem_addr (19) and mem_wdata (24), plus input mem_rdata (24), for a single-port synchronous-read memory.
REQ-009 SHALL have port wr_level, output, 3 bits: the FIFO occupancy, 0..4.

Function
REQ-010 SHALL form the read address as {h_addr, v_addr}, 19 bits, which is the address layout of the existing video memory.
REQ-011 SHALL give reads absolute priority: a read is granted on every cycle where rd_en=1 is sampled.
REQ-012 SHALL drive all mem_* outputs from registers; a read sampled at edge N drives mem_en=1, mem_we=0 and mem_addr during cycle N+1.
REQ-013 SHALL assert rd_valid=1 in cycle N+2 with rd_data=mem_rdata (fixed latency of 2); rd_data SHALL be 0 whenever rd_valid=0.
REQ-014 SHALL contain a 4-entry FIFO of {addr, data}; a push occurs when wr_valid=1 and wr_ready=1 at an edge.
REQ-015 SHALL drive wr_ready = !full, with no dependency on the same-cycle pop, so a full FIFO rejects a push even when a pop occurs in the same cycle.
REQ-016 SHALL pop the FIFO head at an edge where rd_en=0 and the FIFO is not empty; the next cycle then drives mem_en=1, mem_we=1 and the head's addr/data.
REQ-017 SHALL provide no empty-FIFO bypass: a write reaches memory at the earliest 2 cycles after it is accepted.
REQ-018 SHALL allow a push and a pop at the same edge; the occupancy is then unchanged.
REQ-019 SHALL drive mem_en=0, mem_we=0 and mem_addr/mem_wdata=0 in cycles with no grant.
REQ-020 SHALL implement a grant FSM with states IDLE, RD and WR. RD is entered when rd_en=1. WR is entered when rd_en=0 and the FIFO is non-empty. IDLE is entered otherwise.
REQ-021 SHALL keep writes in the FIFO unboundedly while rd_en stays high, so writes drain during blanking; wr_valid SHALL simply stall on wr_ready.
REQ-022 SHALL wrap the FIFO pointers modulo 4 and update wr_level on every push and pop.

Reset
REQ-023 SHALL, while rst=1 at an edge, set the FSM to IDLE, flush the FIFO and drive every output to 0, including wr_ready.
REQ-024 SHALL discard in-flight reads and queued writes on a reset that arrives mid-operation; rd_valid SHALL NOT assert for a read sampled before the reset.
REQ-025 SHALL assert wr_ready=1 in the first cycle after rst is deasserted.

Configuration
REQ-026 SHALL, when VMEM_ARBITER_STATS_EN is defined, add the outputs stall_cnt (16 bits) and wr_cnt (16 bits). stall_cnt counts cycles with wr_valid=1 and wr_ready=0. wr_cnt counts memory writes issued. Both counters saturate at 0xFFFF and clear on rst.
REQ-027 SHALL, when VMEM_ARBITER_STATS_EN is undefined, omit those ports and counters, with no other behavioural change.

Structure
REQ-028 SHALL place ADDR_W=19, DATA_W=24, FIFO_DEPTH=4 and the grant-state enum in the shared package vmem_arbiter_pkg.
REQ-029 SHALL implement the FIFO as the sub-module vmem_wfifo, with push, pop, full, empty and level ports.

Verification
REQ-030 SHALL check a single read: rd_en=1 with h_addr=0x005 and v_addr=0x003 at edge 0 -> mem_addr=0x00A03 and mem_we=0 in cycle 1; rd_valid=1 and rd_data=mem_rdata in cycle 2.
REQ-031 SHALL check a write during blanking: rd_en=0, push addr=0x12345 data=0xFF8000 -> mem_we=1, mem_addr=0x12345, mem_wdata=0xFF8000 two cycles later; wr_level returns to 0.
REQ-032 SHALL check contention: rd_en held at 1 while 5 writes are offered -> 4 writes accepted, wr_ready=0 with level 4 and no mem_we; after rd_en drops, 4 consecutive writes are issued in FIFO order.
REQ-033 SHALL check simultaneous push and pop: level 2 with rd_en=0 and wr_valid=1 -> level stays 2 and one write is issued.
REQ-034 SHALL check reset mid-operation: rst=1 one cycle after a read and with 3 queued writes -> no rd_valid, no mem_we, wr_level=0 and wr_ready=0, then wr_ready=1 one cycle after release.
REQ-035 SHALL check the stats build: with VMEM_ARBITER_STATS_EN defined, 10 stalled cycles -> stall_cnt=10; and wr_cnt equals the number of mem_we pulses.

Source files
------------

// File: rtl/vmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vmem_arbiter_pkg
// Brief    : Shared widths, grant-state encoding and write-entry type for the
//            video-memory arbiter and its write FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package vmem_arbiter_pkg;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int H_W        = 10;
    localparam int V_W        = 9;
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STAT_W     = 16;

    // Grant state: what the memory port is doing in the current cycle
    typedef logic [1:0] grant_state_t;
    localparam grant_state_t ST_IDLE = 2'd0;
    localparam grant_state_t ST_RD   = 2'd1;
    localparam grant_state_t ST_WR   = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Video memory is laid out column-major: horizontal coordinate in the MSBs
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [H_W-1:0] h,
        input logic [V_W-1:0] v
    );
        return {h, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_wfifo.sv
`default_nettype none
// ============================================================================
// Module   : vmem_wfifo
// Brief    : Small first-word-fall-through FIFO holding pending pixel writes.
// Revision : 1.0 - initial release
// ============================================================================
module vmem_wfifo
    import vmem_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  wr_entry_t          push_entry,
    input  logic               pop,
    output wr_entry_t          head,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    wr_entry_t          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (r_level == LEVEL_W'(FIFO_DEPTH));
    assign empty     = (r_level == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];
    assign level     = r_level;

    // Storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vmem_arbiter
// Brief    : Read-priority arbiter between VGA scan-out and a queued write
//            client on a single-port video memory. Optional counters are built
//            when VMEM_ARBITER_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module vmem_arbiter
    import vmem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [H_W-1:0]      h_addr,
    input  logic [V_W-1:0]      v_addr,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_valid,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [LEVEL_W-1:0]  wr_level
`ifdef VMEM_ARBITER_STATS_EN
    ,
    output logic [STAT_W-1:0]   stall_cnt,
    output logic [STAT_W-1:0]   wr_cnt
`endif
);

    grant_state_t r_state;
    grant_state_t w_state_nxt;
    logic         r_ready_en;
    logic         r_rd_valid;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    wr_entry_t    w_head;
    wr_entry_t    w_push_entry;

    // Held low for one cycle after reset so wr_ready reads 0 straight out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // Ready depends only on occupancy, never on a same-cycle pop
    assign wr_ready     = r_ready_en & ~w_full;
    assign w_push       = wr_valid & wr_ready;
    assign w_pop        = ~rd_en & ~w_empty;
    assign w_push_entry = '{addr: wr_addr, data: wr_data};

    vmem_wfifo u_wfifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .level      (wr_level)
    );

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (rd_en) begin
            w_state_nxt = ST_RD;
        end else if (!w_empty) begin
            w_state_nxt = ST_WR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (w_state_nxt)
                ST_RD: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= pixel_addr(h_addr, v_addr);
                    mem_wdata <= '0;
                end
                ST_WR: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= w_head.addr;
                    mem_wdata <= w_head.data;
                end
                default: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

    // The memory returns data one cycle after the RD grant cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= (r_state == ST_RD);
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_valid ? mem_rdata : '0;

`ifdef VMEM_ARBITER_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_wr_cnt    <= '0;
        end else begin
            if (wr_valid && !wr_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
            end
            if (w_pop && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + STAT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign wr_cnt    = r_wr_cnt;
`endif

endmodule
`default_nettype wire
